// File: rtl/opb_pulse_gen_pkg.sv
// Shared register map, channel mode encoding and ID word for the OPB pulse generator.
package opb_pulse_gen_pkg;

   // Per-channel register offsets (ADDR[1:0])
   localparam logic [1:0] R_DIV   = 2'd0;
   localparam logic [1:0] R_CTRL  = 2'd1;
   localparam logic [1:0] R_PHASE = 2'd2;
   localparam logic [1:0] R_CNT   = 2'd3;

   // Global page offsets
   localparam logic [1:0] R_SYNC  = 2'd0;
   localparam logic [1:0] R_ID    = 2'd1;

   localparam logic [15:0] ID_MAGIC = 16'h0C6E;
   localparam logic [7:0]  ID_REV   = 8'h01;

   typedef enum logic [1:0] {
      MODE_PULSE   = 2'd0,
      MODE_SQUARE  = 2'd1,
      MODE_ONESHOT = 2'd2,
      MODE_PULSE_3 = 2'd3
   } mode_e;

   function automatic logic [31:0] id_word(input int num_ch);
      return {ID_MAGIC, 8'(num_ch), ID_REV};
   endfunction

endpackage

// File: rtl/opb_pulse_gen_if.sv
// OPB register-bus signals for the pulse generator; master drives the strobes, slave returns data.
interface opb_pulse_gen_if;
   logic [7:0]  OPB_ADDR;
   logic [31:0] OPB_DI;
   logic        OPB_WE;
   logic        OPB_RE;
   logic [31:0] OPB_DO;

   modport master (output OPB_ADDR, OPB_DI, OPB_WE, OPB_RE, input OPB_DO);
   modport slave  (input OPB_ADDR, OPB_DI, OPB_WE, OPB_RE, output OPB_DO);
endinterface

// File: rtl/pulse_gen_ch.sv
// One pulse/clock channel: down-counter with shadowed divider reload and PULSE/SQUARE/ONESHOT output.
module pulse_gen_ch
   import opb_pulse_gen_pkg::*;
#(
   parameter int DIV_W    = 16,
   parameter int DIV_DFLT = 25
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  mode_e            mode_i,
   input  logic [DIV_W-1:0] shadow_i,
   input  logic [DIV_W-1:0] phase_i,
   input  logic             start_i,
   output logic [DIV_W-1:0] cnt_o,
   output logic             oneshot_clr_o,
   output logic             out_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] act_q, act_d;
   logic             out_q, out_d;
   logic             run;
   logic             tc;

   // Last count value of a period; a zero divider parks the counter at 0.
   function automatic logic [DIV_W-1:0] last_count(input logic [DIV_W-1:0] div);
      return (div == '0) ? '0 : div - 1'b1;
   endfunction

   // NOTE: every variable gets its default before any branch, so no path leaves one unassigned (no latch).
   always_comb begin
      run           = en_i && (act_q != '0);
      tc            = run && (cnt_q == '0);
      cnt_d         = cnt_q;
      act_d         = act_q;
      out_d         = out_q;
      oneshot_clr_o = 1'b0;

      if (start_i) begin
         act_d = shadow_i;
         cnt_d = (phase_i > last_count(shadow_i)) ? last_count(shadow_i) : phase_i;
         out_d = 1'b0;
      end else if (!run) begin
         out_d = 1'b0;
      end else begin
         // The divider only changes hands at TC, so a period is never cut short.
         if (tc) begin
            act_d = shadow_i;
            cnt_d = last_count(shadow_i);
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
         unique case (mode_i)
            MODE_SQUARE:  out_d = out_q ^ tc;
            MODE_ONESHOT: begin
               out_d         = tc;
               oneshot_clr_o = tc;
            end
            default:      out_d = tc;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         act_q <= DIV_W'(DIV_DFLT);
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         act_q <= act_d;
         out_q <= out_d;
      end
   end

   assign cnt_o = cnt_q;
   assign out_o = out_q;

endmodule

// File: rtl/opb_pulse_gen_n.sv
// N-channel programmable pulse/clock generator: OPB decode, per-channel DIV/CTRL/PHASE, SYNC fan-out.
module opb_pulse_gen_n
   import opb_pulse_gen_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int DIV_W    = 16,
   parameter int DIV_DFLT = 25
) (
   input  logic                OPB_CLK,
   input  logic                OPB_RST_N,
   opb_pulse_gen_if.slave      bus,
   output logic [NUM_CH-1:0]   CH_OUT
);

   logic [5:0]        idx;
   logic [1:0]        rsel;
   logic              sync_wr;
   logic [DIV_W-1:0]  div_q   [NUM_CH];
   logic [DIV_W-1:0]  div_d   [NUM_CH];
   logic [DIV_W-1:0]  phase_q [NUM_CH];
   logic [DIV_W-1:0]  phase_d [NUM_CH];
   mode_e             mode_q  [NUM_CH];
   mode_e             mode_d  [NUM_CH];
   logic [DIV_W-1:0]  cnt     [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] start;
   logic [NUM_CH-1:0] oneshot_clr;
   logic [31:0]       rdata;
   logic [31:0]       do_q, do_d;
   logic              unused_di;

   assign idx       = bus.OPB_ADDR[7:2];
   assign rsel      = bus.OPB_ADDR[1:0];
   assign sync_wr   = bus.OPB_WE && (idx == 6'(NUM_CH)) && (rsel == R_SYNC);
   assign unused_di = ^bus.OPB_DI;

   always_comb begin
      div_d   = div_q;
      phase_d = phase_q;
      mode_d  = mode_q;
      en_d    = en_q & ~oneshot_clr;
      start   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (bus.OPB_WE && (idx == 6'(c))) begin
            case (rsel)
               R_DIV:   div_d[c] = bus.OPB_DI[DIV_W-1:0];
               R_CTRL: begin
                  // A software CTRL write overrides a same-cycle one-shot clear.
                  en_d[c]   = bus.OPB_DI[0];
                  mode_d[c] = mode_e'(bus.OPB_DI[2:1]);
                  start[c]  = bus.OPB_DI[0] && !en_q[c];
               end
               R_PHASE: phase_d[c] = bus.OPB_DI[DIV_W-1:0];
               default: ;
            endcase
         end
         if (sync_wr && bus.OPB_DI[c] && en_q[c]) start[c] = 1'b1;
      end
   end

   always_comb begin
      rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (idx == 6'(c)) begin
            case (rsel)
               R_DIV:   rdata = 32'(div_q[c]);
               R_CTRL:  rdata = 32'({mode_q[c], en_q[c]});
               R_PHASE: rdata = 32'(phase_q[c]);
               default: rdata = 32'(cnt[c]);
            endcase
         end
      end
      if ((idx == 6'(NUM_CH)) && (rsel == R_ID)) rdata = id_word(NUM_CH);
      do_d = bus.OPB_RE ? rdata : '0;
   end

   // NOTE: these register arrays are control state, not RAM, so every element is reset.
   always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
      if (!OPB_RST_N) begin
         div_q   <= '{default: DIV_W'(DIV_DFLT)};
         phase_q <= '{default: '0};
         mode_q  <= '{default: MODE_PULSE};
         en_q    <= '0;
         do_q    <= '0;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
         mode_q  <= mode_d;
         en_q    <= en_d;
         do_q    <= do_d;
      end
   end

   assign bus.OPB_DO = do_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      pulse_gen_ch #(
         .DIV_W    (DIV_W),
         .DIV_DFLT (DIV_DFLT)
      ) u_ch (
         .clk           (OPB_CLK),
         .rst_n         (OPB_RST_N),
         .en_i          (en_q[c]),
         .mode_i        (mode_q[c]),
         .shadow_i      (div_q[c]),
         .phase_i       (phase_q[c]),
         .start_i       (start[c]),
         .cnt_o         (cnt[c]),
         .oneshot_clr_o (oneshot_clr[c]),
         .out_o         (CH_OUT[c])
      );
   end

endmodule

// File: tb/tb_opb_pulse_gen_n.sv
// Directed bench for opb_pulse_gen_n: register reads scored through a queue, CH_OUT checked per cycle.
module tb_opb_pulse_gen_n;
   import opb_pulse_gen_pkg::*;

   localparam int          NUM_CH  = 8;
   localparam logic [31:0] ID_EXP  = 32'h0C6E_0801;
   localparam logic [7:0]  A_SYNC  = 8'h20;
   localparam logic [7:0]  A_ID    = 8'h21;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [NUM_CH-1:0] ch_out;
   int                checks = 0;
   int                errors = 0;
   logic [31:0]       rd_exp_q [$];
   string             rd_tag_q [$];
   logic              found;

   opb_pulse_gen_if bus ();

   opb_pulse_gen_n #(.NUM_CH(NUM_CH), .DIV_W(16), .DIV_DFLT(25)) dut (
      .OPB_CLK   (clk),
      .OPB_RST_N (rst_n),
      .bus       (bus),
      .CH_OUT    (ch_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] exp);
      check(tag, 32'(ch_out), 32'(exp));
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.OPB_ADDR = a;
      bus.OPB_DI   = d;
      bus.OPB_WE   = 1'b1;
      @(negedge clk);
      bus.OPB_WE   = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
      @(negedge clk);
      bus.OPB_ADDR = a;
      bus.OPB_RE   = 1'b1;
      rd_exp_q.push_back(exp);
      rd_tag_q.push_back(tag);
      @(negedge clk);
      bus.OPB_RE   = 1'b0;
      check(rd_tag_q.pop_front(), bus.OPB_DO, rd_exp_q.pop_front());
   endtask

   initial begin
      bus.OPB_ADDR = '0;
      bus.OPB_DI   = '0;
      bus.OPB_WE   = 1'b0;
      bus.OPB_RE   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_out("reset_ch_out", 8'h00);
      check("reset_do", bus.OPB_DO, 32'h0);
      rst_n = 1'b1;
      rd(8'h00, 32'd25, "ch0_div_default");
      rd(A_ID, ID_EXP, "id_word");
      @(negedge clk);
      check("do_idle_after_read", bus.OPB_DO, 32'h0);
      check_out("idle_ch_out", 8'h00);

      // ch0 PULSE DIV=5: first pulse one cycle after start, then every 5
      wr(8'h00, 32'd5);
      wr(8'h01, 32'h1);
      for (int k = 0; k < 12; k++) begin
         check_out($sformatf("pulse5_k%0d", k), (k % 5 == 1) ? 8'h01 : 8'h00);
         @(negedge clk);
      end
      wr(8'h01, 32'h0);
      @(negedge clk);
      check_out("ch0_disabled", 8'h00);
      rd(8'h00, 32'd5, "ch0_div_rb");

      // ch1 SQUARE DIV=3: 3 high / 3 low
      wr(8'h04, 32'd3);
      wr(8'h05, 32'h3);
      for (int k = 0; k < 13; k++) begin
         check_out($sformatf("sq3_k%0d", k),
                   (k >= 1 && ((k - 1) / 3) % 2 == 0) ? 8'h02 : 8'h00);
         @(negedge clk);
      end
      // DIV=4 written mid high-phase: that phase keeps 3 cycles, then 4/4
      wr(8'h04, 32'd4);
      for (int j = 0; j < 13; j++) begin
         check_out($sformatf("sq4_j%0d", j),
                   (j == 0 || ((j - 1) / 4) % 2 == 1) ? 8'h02 : 8'h00);
         @(negedge clk);
      end
      rd(8'h04, 32'd4, "ch1_div_rb");
      wr(8'h05, 32'h0);
      @(negedge clk);
      check_out("ch1_disabled", 8'h00);

      // ch2 ONESHOT DIV=10: single pulse, EN self-clears
      wr(8'h08, 32'd10);
      wr(8'h09, 32'h5);
      for (int k = 0; k <= 100; k++) begin
         check_out($sformatf("oneshot_k%0d", k), (k == 1) ? 8'h04 : 8'h00);
         @(negedge clk);
      end
      rd(8'h09, 32'h4, "ch2_ctrl_en_cleared");

      // ch0/ch1 DIV=8, PHASE 0/4, restarted together by SYNC
      wr(8'h00, 32'd8);
      wr(8'h02, 32'd0);
      wr(8'h01, 32'h1);
      wr(8'h04, 32'd8);
      wr(8'h06, 32'd4);
      wr(8'h05, 32'h1);
      wr(A_SYNC, 32'h3);
      for (int k = 0; k < 25; k++) begin
         check_out($sformatf("sync_k%0d", k),
                   ((k % 8 == 1) ? 8'h01 : 8'h00) | ((k % 8 == 5) ? 8'h02 : 8'h00));
         @(negedge clk);
      end
      wr(8'h01, 32'h0);
      wr(8'h05, 32'h0);
      @(negedge clk);
      check_out("sync_chs_disabled", 8'h00);

      // SYNC on disabled channels has no effect
      wr(A_SYNC, 32'hFF);
      for (int k = 0; k < 6; k++) begin
         check_out($sformatf("sync_disabled_k%0d", k), 8'h00);
         @(negedge clk);
      end

      // ch5 DIV=1 PULSE: constant high after start
      wr(8'h14, 32'd1);
      wr(8'h15, 32'h1);
      for (int k = 0; k < 6; k++) begin
         check_out($sformatf("div1_k%0d", k), (k >= 1) ? 8'h20 : 8'h00);
         @(negedge clk);
      end
      wr(8'h15, 32'h0);
      @(negedge clk);
      check_out("ch5_disabled", 8'h00);

      // Width truncation, RO/WO/unmapped accesses
      wr(8'h10, 32'hABCD_1234);
      rd(8'h10, 32'h0000_1234, "div_upper_bits_dropped");
      wr(A_ID, 32'h0);
      rd(A_ID, ID_EXP, "id_write_ignored");
      rd(A_SYNC, 32'h0, "sync_reads_zero");
      rd(8'h22, 32'h0, "global_r2_unmapped");
      rd(8'h24, 32'h0, "page9_unmapped");

      // Async reset while ch1 SQUARE output is high
      wr(8'h04, 32'd3);
      wr(8'h06, 32'd2);
      wr(8'h05, 32'h3);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (ch_out[1]) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rst_wait_square_high", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_out("rst_async_ch_out", 8'h00);
      check("rst_async_do", bus.OPB_DO, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(8'h04, 32'd25, "rst_ch1_div");
      rd(8'h05, 32'h0, "rst_ch1_ctrl");
      rd(8'h06, 32'h0, "rst_ch1_phase");
      rd(8'h07, 32'h0, "rst_ch1_cnt");
      for (int k = 0; k < 10; k++) begin
         check_out($sformatf("post_rst_idle_k%0d", k), 8'h00);
         @(negedge clk);
      end

      // ch3 DIV=0 with EN: stays quiet, counter held
      wr(8'h0C, 32'd0);
      wr(8'h0D, 32'h1);
      for (int k = 0; k < 20; k++) begin
         check_out($sformatf("div0_k%0d", k), 8'h00);
         @(negedge clk);
      end
      rd(8'h0D, 32'h1, "div0_ctrl_en");
      rd(8'h0F, 32'h0, "div0_cnt_held");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
